// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch and sequencing unit for the 24-bit CPU.
// Owns the PC, fetches instruction words over a req/ack handshake and
// presents the instruction plus its opcode to the control unit.
// Optional feature macro: IFETCH_ILLEGAL_TRAP_EN adds an illegal-opcode
// trap with a terminal HALT state. Without it IllegalOp is tied low.

module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              ResetN,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic              IMemAck,
    input  logic [23:0]       IMemData,
    input  logic              Stall,
    input  logic              Branch,
    input  logic              Jump,
    input  logic              Zero,
    output logic [23:0]       Instr,
    output logic [3:0]        OPCODE,
    output logic              InstrValid,
    output logic [ADDR_W-1:0] PC,
    output logic              IllegalOp
);

`ifdef IFETCH_ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
`endif

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pc_reg;
    logic [23:0]       instr_reg;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] branch_offset;
    logic              load_instr;
    logic              load_pc;

`ifdef IFETCH_ILLEGAL_TRAP_EN
    logic              trap;
    logic              illegal_reg;

    function automatic logic opcode_legal(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction
`endif

    // State register; reset drops straight back to IDLE so all outputs clear at once
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and load strobes for the instruction register and PC
    always_comb begin
        next_state = state;
        load_instr = 1'b0;
        load_pc    = 1'b0;
`ifdef IFETCH_ILLEGAL_TRAP_EN
        trap       = 1'b0;
`endif
        case (state)
            IDLE: begin
                next_state = FETCH;
            end
            FETCH: begin
                if (IMemAck) begin
                    load_instr = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
`ifdef IFETCH_ILLEGAL_TRAP_EN
                if (!opcode_legal(instr_reg[23:20])) begin
                    trap       = 1'b1;
                    next_state = HALT;
                end else
`endif
                if (!Stall) begin
                    load_pc    = 1'b1;
                    next_state = FETCH;
                end
            end
`ifdef IFETCH_ILLEGAL_TRAP_EN
            HALT: begin
                next_state = HALT;
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Next-PC selection: jump target beats a taken branch, which beats a plain step
    always_comb begin
        branch_offset = ADDR_W'({{24{instr_reg[7]}}, instr_reg[7:0]});
        if (Jump) begin
            next_pc = instr_reg[ADDR_W-1:0];
        end else if (Branch && Zero) begin
            next_pc = pc_reg + ADDR_W'(1) + branch_offset;
        end else begin
            next_pc = pc_reg + ADDR_W'(1);
        end
    end

    // PC and instruction register; only the strobes above ever change them
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            pc_reg    <= RESET_PC;
            instr_reg <= '0;
        end else begin
            if (load_instr) begin
                instr_reg <= IMemData;
            end
            if (load_pc) begin
                pc_reg <= next_pc;
            end
        end
    end

`ifdef IFETCH_ILLEGAL_TRAP_EN
    // Sticky trap flag, cleared only by reset
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            illegal_reg <= 1'b0;
        end else if (trap) begin
            illegal_reg <= 1'b1;
        end
    end

    assign IllegalOp = illegal_reg;
`else
    assign IllegalOp = 1'b0;
`endif

    assign IMemReq    = (state == FETCH);
    assign IMemAddr   = pc_reg;
    assign PC         = pc_reg;
    assign Instr      = instr_reg;
    assign OPCODE     = instr_reg[23:20];
    assign InstrValid = (state == ISSUE);

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and sequencing unit for the 24-bit CPU: it owns the PC, fetches 24-bit instruction words from instruction memory over a req/ack handshake, and presents the instruction and its 4-bit `OPCODE` to the control unit. It consumes the control unit's `Branch` and `Jump` outputs, plus the ALU `Zero` flag, to select the next PC. It is the producer end of the opcode/control path, sitting between instruction memory and the decode/execute datapath.

## Interface
- `ADDR_W`, 8, instruction-memory word-address width; PC width.
- `RESET_PC`, 0, PC value loaded on reset.
- `Clock`  input  1  single clock; all state updates on the rising edge.
- `ResetN`  input  1  asynchronous, active-low reset.
- `IMemReq`  output  1  fetch request.
- `IMemAddr`  output  ADDR_W  fetch word address; equals PC.
- `IMemAck`  input  1  memory acknowledge; `IMemData` is valid in the same cycle.
- `IMemData`  input  24  instruction word.
- `Stall`  input  1  holds the current instruction in ISSUE.
- `Branch`  input  1  from the control unit.
- `Jump`  input  1  from the control unit.
- `Zero`  input  1  ALU zero flag.
- `Instr`  output  24  instruction register.
- `OPCODE`  output  4  equals `Instr[23:20]`; drives the control unit.
- `InstrValid`  output  1  high while in ISSUE.
- `PC`  output  ADDR_W  address of the instruction in `Instr`.
- `IllegalOp`  output  1  illegal-opcode trap flag. Present only with the macro; otherwise tied to 0.

## Operation
- States: IDLE, FETCH, ISSUE, HALT (HALT exists only with the macro).
- IDLE: entered on reset. Moves to FETCH on the next edge.
- FETCH:
  - `IMemReq`=1 and `IMemAddr`=PC are held stable until `IMemAck`=1 is sampled.
  - On that edge, `Instr`←`IMemData` and the state moves to ISSUE.
  - `IMemAck` outside FETCH is ignored.
- ISSUE:
  - `InstrValid`=1; the control unit decodes `OPCODE` combinationally.
  - While `Stall`=1: hold the state; `Instr` and PC are unchanged.
  - When `Stall`=0: update the PC on the edge and go to FETCH.
- Next PC, in priority order:
  - `Jump`=1: PC←`Instr[ADDR_W-1:0]`.
  - `Branch`=1 and `Zero`=1: PC←PC+1+sign_extend(`Instr[7:0]`).
  - Otherwise: PC←PC+1.
- Arithmetic: modulo 2^ADDR_W. PC=2^ADDR_W−1 with a sequential step wraps to 0. Negative offsets wrap the same way.
- `Branch`=1 with `Zero`=0 is a sequential step.
- `Jump`=1 and `Branch`=1 together: `Jump` wins.
- `Branch`, `Jump`, `Zero` and `Stall` are sampled only in ISSUE; they are don't-care elsewhere.

## Timing
- Reset values: `IMemReq`=0, `IMemAddr`=`RESET_PC`, `Instr`=0, `OPCODE`=0, `InstrValid`=0, `PC`=`RESET_PC`, `IllegalOp`=0. State is IDLE.
- Reset asserted at any time, including mid-FETCH with `IMemReq` high, clears all outputs immediately and asynchronously. A pending ack is discarded.
- First `IMemReq` appears 1 cycle after `ResetN` deasserts.
- Minimum instruction period is 2 cycles: FETCH with ack in the first cycle, then 1 ISSUE cycle.
- Each extra wait cycle on `IMemAck` adds 1 cycle. Each `Stall` cycle adds 1 cycle.
- `IMemReq` drops in the cycle after the ack. It reasserts after ISSUE completes with the new PC.

## Configuration
- `IFETCH_ILLEGAL_TRAP_EN` defined:
  - Legal opcodes are 0001, 0010, 0011, 0100 and 0110.
  - Any other opcode in ISSUE sets `IllegalOp`=1 on the next edge and enters HALT, ignoring `Stall`.
  - HALT: `IMemReq`=0, `InstrValid`=0; `Instr` and PC are frozen at the faulting instruction. Only reset exits HALT.
- `IFETCH_ILLEGAL_TRAP_EN` undefined:
  - No HALT state; `IllegalOp` is tied to 0.
  - Illegal opcodes issue normally and advance PC+1, unless `Jump` or `Branch` is asserted.

## Test plan
- Reset with `RESET_PC`=0 and zero-wait memory returning 0x1xxxxx -> first `IMemReq`/`IMemAddr`=0 one cycle after reset; `OPCODE`=0001 with `InstrValid` the next cycle; next fetch at address 1.
- Ack delayed 3 cycles -> `IMemReq` and `IMemAddr` stable for 4 cycles; `Instr` captured on the ack edge only.
- `Branch`=1, `Zero`=1, `Instr[7:0]`=0xFE at PC=5 -> next fetch at 4. Same instruction with `Zero`=0 -> next fetch at 6.
- `Jump`=1 and `Branch`=1 together, `Instr[7:0]`=0x20 -> next fetch at 0x20. PC=0xFF with a sequential step -> next fetch at 0x00.
- `Stall` held for 2 ISSUE cycles -> `InstrValid` high for 3 cycles, `Instr`/PC unchanged. Reset asserted mid-FETCH -> `IMemReq`=0 and PC=0 immediately.
- With the macro defined, opcode 1111 -> `IllegalOp`=1 and no further `IMemReq` until reset. Without the macro -> PC advances by 1 and `IllegalOp`=0.
